ram_march_ctrl: RTL and testbench

RAM_MARCH_CTRL -- requirements
Module: ram_march_ctrl

---
 rtl/ram_march_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ram_march_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_march_ctrl.sv
// ram_march_ctrl -- March C- built-in self-test controller for a single-port RAM.
//
// Runs the six March C- elements (P0 = all-zeros, P1 = all-ones):
//   M0 up{w0}  M1 up{r0,w1}  M2 up{r1,w0}  M3 dn{r0,w1}  M4 dn{r1,w0}  M5 dn{r0}
// A write is one WR cycle. A read is an RD cycle (read_en strobe) followed by
// a CMP cycle, during which the RAM's registered read data is valid; the
// compare happens at the edge that ends CMP. Operations are issued
// back-to-back, so a run is 15*N cycles long.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         run request, sampled only in IDLE
//   read_en       RAM read strobe (registered)
//   write_en      RAM write strobe (registered)
//   address_loc   RAM address (registered)
//   data_inbit    RAM write data (registered)
//   data_outbit   RAM read data, valid in the CMP cycle
//   busy          high for every operation cycle of a run
//   done          one-cycle pulse after the final compare
//   pass          set with done when the run saw no mismatches
//   fail_addr     address of the first mismatching read in the run
//   err_count     mismatching reads in the run, saturating at 16'hFFFF
module ram_march_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_BUS_WIDTH = 4,
    parameter int MAX_MEM_LOC    = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      read_en,
    output logic                      write_en,
    output logic [ADDR_BUS_WIDTH-1:0] address_loc,
    output logic [DATA_WIDTH-1:0]     data_inbit,
    input  logic [DATA_WIDTH-1:0]     data_outbit,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ADDR_BUS_WIDTH-1:0] fail_addr,
    output logic [15:0]               err_count
);

    typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

    localparam logic [ADDR_BUS_WIDTH-1:0] LAST = ADDR_BUS_WIDTH'(MAX_MEM_LOC);
    localparam logic [ADDR_BUS_WIDTH-1:0] ONE  = ADDR_BUS_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]     P0   = '0;
    localparam logic [DATA_WIDTH-1:0]     P1   = '1;

    state_t                      state, state_nxt;
    logic [2:0]                  elem, elem_nxt;
    logic [ADDR_BUS_WIDTH-1:0]   addr, addr_nxt;

    // Registered-output next values
    logic                        read_en_d, write_en_d, busy_d, done_d, pass_d;
    logic [ADDR_BUS_WIDTH-1:0]   address_d, fail_d;
    logic [DATA_WIDTH-1:0]       data_d;
    logic [15:0]                 err_d;

    logic                        down, at_end, mismatch;
    logic [DATA_WIDTH-1:0]       exp_rd;

    // Elements 3..5 walk downwards; element index parity selects patterns:
    // odd elements read P0 and write P1, even elements read P1 and write P0.
    assign down     = (elem >= 3'd3);
    assign at_end   = down ? (addr == '0) : (addr == LAST);
    assign exp_rd   = elem[0] ? P0 : P1;
    // Case inequality so X/Z on the read bus counts as a mismatch.
    assign mismatch = (state == CMP) && (data_outbit !== exp_rd);

    // State, counters and all RAM-facing outputs are registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            elem        <= '0;
            addr        <= '0;
            read_en     <= 1'b0;
            write_en    <= 1'b0;
            address_loc <= '0;
            data_inbit  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            elem        <= elem_nxt;
            addr        <= addr_nxt;
            read_en     <= read_en_d;
            write_en    <= write_en_d;
            address_loc <= address_d;
            data_inbit  <= data_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            fail_addr   <= fail_d;
            err_count   <= err_d;
        end
    end

    // Next state / element / address
    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        addr_nxt  = addr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WR;
                    elem_nxt  = '0;
                    addr_nxt  = '0;
                end
            end
            WR: begin
                // The write is the last operation at an address (M0-M4).
                // Only M0 consists of writes alone; every other element
                // continues with a read.
                state_nxt = (elem == 3'd0 && !at_end) ? WR : RD;
                if (at_end) begin
                    elem_nxt = elem + 3'd1;
                    addr_nxt = (elem >= 3'd2) ? LAST : '0;
                end else begin
                    addr_nxt = down ? addr - ONE : addr + ONE;
                end
            end
            RD: state_nxt = CMP;
            CMP: begin
                if (elem != 3'd5) begin
                    state_nxt = WR;
                end else if (at_end) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD;
                    addr_nxt  = addr - ONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output next values, derived from the upcoming state
    always_comb begin
        read_en_d  = (state_nxt == RD);
        write_en_d = (state_nxt == WR);
        busy_d     = (state_nxt inside {WR, RD, CMP});
        done_d     = (state_nxt == DONE);
        address_d  = busy_d ? addr_nxt : '0;
        data_d     = write_en_d ? (elem_nxt[0] ? P1 : P0) : '0;
        err_d      = err_count;
        fail_d     = fail_addr;
        pass_d     = pass;
        if (state == IDLE && start) begin
            err_d  = '0;
            fail_d = '0;
            pass_d = 1'b0;
        end
        if (mismatch) begin
            if (err_count == 16'd0)
                fail_d = addr;
            if (err_count != 16'hFFFF)
                err_d = err_count + 16'd1;
        end
        // Uses err_d so a mismatch on the very last compare is honoured.
        if (state_nxt == DONE)
            pass_d = (err_d == 16'd0);
    end

endmodule

// File: tb/tb_ram_march_ctrl.sv
// tb_ram_march_ctrl -- directed testbench for ram_march_ctrl (N = 16).
// A behavioural RAM with optional bit0 stuck-at faults sits on the bus.
// Table-driven runs check the full bus trace, busy/done timing and results;
// hand-written sequences cover reset mid-run and reset-time behaviour.
module tb_ram_march_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int N   = 16;
    localparam int RUN = 15 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          read_en, write_en, busy, done, pass;
    logic [AW-1:0] address_loc, fail_addr;
    logic [DW-1:0] data_inbit;
    logic [DW-1:0] data_outbit = '0;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    ram_march_ctrl #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .MAX_MEM_LOC(N-1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .read_en(read_en), .write_en(write_en),
        .address_loc(address_loc), .data_inbit(data_inbit),
        .data_outbit(data_outbit),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .err_count(err_count)
    );

    // RAM model: registered read; fault_mode 1 = bit0 stuck-at-1, 2 = stuck-at-0
    logic [DW-1:0] mem [0:N-1];
    int            fault_mode = 0;
    logic [AW-1:0] fault_addr = '0;

    always @(posedge clk) begin : ram
        logic [DW-1:0] rd;
        if (write_en) mem[address_loc] <= data_inbit;
        if (read_en) begin
            rd = mem[address_loc];
            if (address_loc == fault_addr && fault_mode == 1) rd[0] = 1'b1;
            if (address_loc == fault_addr && fault_mode == 2) rd[0] = 1'b0;
            data_outbit <= rd;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected per-cycle bus trace of one run, built from the March C- definition
    typedef struct {
        bit            re;
        bit            we;
        bit            chk_addr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } op_t;
    op_t ops [RUN];

    task automatic build_trace();
        int i = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                logic [AW-1:0] a;
                a = (e < 3) ? AW'(k) : AW'(N - 1 - k);
                if (e > 0) begin
                    ops[i].re = 1; ops[i].we = 0; ops[i].chk_addr = 1; ops[i].addr = a; ops[i].wd = '0; i++;
                    ops[i].re = 0; ops[i].we = 0; ops[i].chk_addr = 0; ops[i].addr = a; ops[i].wd = '0; i++;
                end
                if (e < 5) begin
                    ops[i].re = 0; ops[i].we = 1; ops[i].chk_addr = 1; ops[i].addr = a;
                    ops[i].wd = (e % 2 == 1) ? 8'hFF : 8'h00; i++;
                end
            end
        end
    endtask

    typedef struct {
        string         name;
        int            fmode;
        logic [AW-1:0] faddr;
        bit            hold;
        bit            exp_pass;
        logic [AW-1:0] exp_fa;
        int            exp_err;
    } vec_t;
    vec_t vecs [5];

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int busy_cnt = 0, trace_err = 0, m0_wr = 0, rw_both = 0;
        fault_mode = v.fmode;
        fault_addr = v.faddr;
        @(negedge clk); start = 1'b1;
        @(negedge clk);                       // first operation cycle
        if (!v.hold) start = 1'b0;
        check({v.name, " cleared"}, 64'({pass, fail_addr, err_count}), 64'(0));
        for (int c = 0; c < RUN; c++) begin
            if (busy) busy_cnt++;
            if (read_en && write_en) rw_both++;
            if (c < N && write_en) m0_wr++;
            if (read_en !== ops[c].re || write_en !== ops[c].we || done !== 1'b0 ||
                (ops[c].chk_addr && address_loc !== ops[c].addr) ||
                (ops[c].we && data_inbit !== ops[c].wd)) begin
                if (trace_err == 0)
                    $display("%s: first trace deviation at cycle %0d re=%b we=%b addr=%0d wd=%0h",
                             v.name, c, read_en, write_en, address_loc, data_inbit);
                trace_err++;
            end
            @(negedge clk);
        end
        check({v.name, " trace"},     64'(trace_err), 64'(0));
        check({v.name, " busy_cyc"},  64'(busy_cnt),  64'(RUN));
        check({v.name, " rw_both"},   64'(rw_both),   64'(0));
        check({v.name, " m0_writes"}, 64'(m0_wr),     64'(N));
        check({v.name, " done"},      64'({done, busy}), 64'(2'b10));
        check({v.name, " pass"},      64'(pass),      64'(v.exp_pass));
        check({v.name, " err_count"}, 64'(err_count), 64'(v.exp_err));
        check({v.name, " fail_addr"}, 64'(fail_addr), 64'(v.exp_fa));
        @(negedge clk);                       // back in IDLE
        check({v.name, " idle"}, 64'({done, busy, read_en, write_en, address_loc, data_inbit}), 64'(0));
        if (v.hold) begin
            // start still high: exactly one new run launched from this IDLE
            @(negedge clk);
            check({v.name, " restart"}, 64'({busy, write_en, address_loc}), 64'({1'b1, 1'b1, AW'(0)}));
            start = 1'b0;
            pulse_reset();
        end else begin
            check({v.name, " pass_hold"}, 64'({pass, err_count}), 64'({v.exp_pass, 16'(v.exp_err)}));
        end
    endtask

    initial begin
        vecs[0] = '{"clean",      0, 4'd0,  0, 1, 4'd0,  0};
        vecs[1] = '{"sa1_a5",     1, 4'd5,  0, 0, 4'd5,  3};
        vecs[2] = '{"sa0_a5",     2, 4'd5,  0, 0, 4'd5,  2};
        vecs[3] = '{"sa1_a15",    1, 4'd15, 0, 0, 4'd15, 3};
        vecs[4] = '{"start_hold", 0, 4'd0,  1, 1, 4'd0,  0};
        build_trace();

        // Reset state, and start ignored while reset is held
        #2 rst_n = 1'b0;
        #1 check("reset_state", 64'({read_en, write_en, busy, done, pass, address_loc,
                                    data_inbit, fail_addr, err_count}), 64'(0));
        start = 1'b1;
        @(negedge clk); @(negedge clk);
        check("start_in_reset", 64'({busy, write_en}), 64'(0));
        start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset during M3 of a faulty run, then a clean run
        fault_mode = 1; fault_addr = 4'd5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (125) @(negedge clk);          // inside M3 (cycles 112..159)
        check("midrun_state", 64'({busy, err_count, fail_addr}), 64'({1'b1, 16'd1, 4'd5}));
        #2 rst_n = 1'b0;
        #1 check("async_reset", 64'({read_en, write_en, busy, done, pass, address_loc,
                                    data_inbit, fail_addr, err_count}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'({busy, read_en, write_en}), 64'(0));
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
